// File: rtl/shake_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared SHAKE sponge, clearing the sponge on every new grant.
// Build option: define SHAKE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module shake_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 64,
  localparam int LEN_W    = $clog2(DATA_BITS) + 1,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OFF_W    = IDX_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           rel,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         busy,
  input  logic [NUM_REQ*DATA_BITS-1:0] u_data_in,
  input  logic [NUM_REQ-1:0]           u_in_valid,
  input  logic [NUM_REQ-1:0]           u_in_last,
  input  logic [NUM_REQ-1:0]           u_out_ready,
  input  logic [NUM_REQ*LEN_W-1:0]     u_last_len,
  output logic [DATA_BITS-1:0]         u_data_out,
  output logic [NUM_REQ-1:0]           u_in_ready,
  output logic [NUM_REQ-1:0]           u_out_valid,
  output logic [DATA_BITS-1:0]         s_data_in,
  output logic                         s_in_valid,
  output logic                         s_in_last,
  output logic                         s_out_ready,
  output logic [LEN_W-1:0]             s_last_len,
  input  logic [DATA_BITS-1:0]         s_data_out,
  input  logic                         s_out_valid,
  input  logic                         s_in_ready,
  output logic                         s_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic               busy_r;
  logic               s_clr_r;
  logic [IDX_W-1:0]   win_idx_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [NUM_REQ-1:0] sel_s;
  logic               any_req_s;
  logic               rel_hit_s;
  logic               active_s;
`ifndef SHAKE_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] req_rot_s;
  logic [OFF_W-1:0]   off_s;
  logic [OFF_W-1:0]   sum_s;
`endif

  assign any_req_s = |req;
  assign rel_hit_s = |(rel & gnt_r);
  assign active_s  = (state_r == ACTIVE);
  assign sel_s     = gnt_r & {NUM_REQ{active_s}};
  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign s_clr     = s_clr_r;

  // Winner selection: descending scan so the first candidate in search order is kept last.
  always_comb begin
    win_idx_s = '0;
`ifdef SHAKE_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      win_idx_s = req[k] ? IDX_W'(k) : win_idx_s;
    end
`else
    req_rot_s = NUM_REQ'({req, req} >> ({1'b0, ptr_r} + OFF_W'(1)));
    off_s     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      off_s = req_rot_s[k] ? OFF_W'(k) : off_s;
    end
    sum_s     = {1'b0, ptr_r} + OFF_W'(1) + off_s;
    win_idx_s = (sum_s >= OFF_W'(NUM_REQ)) ? IDX_W'(sum_s - OFF_W'(NUM_REQ))
                                           : IDX_W'(sum_s);
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh_s[i] = (win_idx_s == IDX_W'(i));
    end
  end

  // Grant FSM with registered grant, busy and sponge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      busy_r  <= 1'b0;
      s_clr_r <= 1'b0;
`ifndef SHAKE_ARB_FIXED_PRIO_EN
      ptr_r   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      s_clr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= CLEAR;
            gnt_r   <= win_oh_s;
            busy_r  <= 1'b1;
            s_clr_r <= 1'b1;
`ifndef SHAKE_ARB_FIXED_PRIO_EN
            ptr_r   <= win_idx_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          state_r <= ACTIVE;
        end
        ACTIVE: begin
          if (rel_hit_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ACTIVE;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stream mux: AND-OR of the one-hot grant, so every output is zero outside ACTIVE.
  always_comb begin
    s_data_in   = '0;
    s_last_len  = '0;
    s_in_valid  = 1'b0;
    s_in_last   = 1'b0;
    s_out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_data_in   = s_data_in  | (u_data_in[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{sel_s[i]}});
      s_last_len  = s_last_len | (u_last_len[i*LEN_W +: LEN_W] & {LEN_W{sel_s[i]}});
      s_in_valid  = s_in_valid  | (u_in_valid[i]  & sel_s[i]);
      s_in_last   = s_in_last   | (u_in_last[i]   & sel_s[i]);
      s_out_ready = s_out_ready | (u_out_ready[i] & sel_s[i]);
    end
    u_in_ready  = sel_s & {NUM_REQ{s_in_ready}};
    u_out_valid = sel_s & {NUM_REQ{s_out_valid}};
    u_data_out  = s_data_out & {DATA_BITS{active_s}};
  end

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: hand-computed grant/clear vector table, then random traffic
// checked against a transaction-level owner/phase model. Honours SHAKE_ARB_FIXED_PRIO_EN.
module tb_shake_arbiter;
  localparam int N  = 4;
  localparam int DB = 64;
  localparam int LW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, rel, gnt, u_in_valid, u_in_last, u_out_ready, u_in_ready, u_out_valid;
  logic            busy, s_in_valid, s_in_last, s_out_ready, s_out_valid, s_in_ready, s_clr;
  logic [N*DB-1:0] u_data_in;
  logic [N*LW-1:0] u_last_len;
  logic [DB-1:0]   u_data_out, s_data_in, s_data_out;
  logic [LW-1:0]   s_last_len;

  int vectors = 0;
  int miscompares = 0;

  shake_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt), .busy(busy),
    .u_data_in(u_data_in), .u_in_valid(u_in_valid), .u_in_last(u_in_last),
    .u_out_ready(u_out_ready), .u_last_len(u_last_len), .u_data_out(u_data_out),
    .u_in_ready(u_in_ready), .u_out_valid(u_out_valid), .s_data_in(s_data_in),
    .s_in_valid(s_in_valid), .s_in_last(s_in_last), .s_out_ready(s_out_ready),
    .s_last_len(s_last_len), .s_data_out(s_data_out), .s_out_valid(s_out_valid),
    .s_in_ready(s_in_ready), .s_clr(s_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] ordy;
    logic [3:0] gnt;
    logic       busy;
    logic       clr;
    logic       sordy;
  } vec_t;

  vec_t tbl [0:22];

`ifdef SHAKE_ARB_FIXED_PRIO_EN
  localparam logic [3:0] SECOND = 4'b0010;
`else
  localparam logic [3:0] SECOND = 4'b1000;
`endif

  // Reference model: who owns the sponge and which phase (0 idle, 1 clear, 2 active).
  int m_owner, m_phase, m_ptr;

  task automatic model_reset();
    m_owner = -1;
    m_phase = 0;
    m_ptr   = N - 1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int c;
`ifdef SHAKE_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_step();
    if (rst) model_reset();
    else if (m_phase == 0) begin
      if (req != 0) begin
        m_owner = pick(req);
        m_ptr   = m_owner;
        m_phase = 1;
      end
    end else if (m_phase == 1) m_phase = 2;
    else if (rel[m_owner]) begin
      m_phase = 0;
      m_owner = -1;
    end
  endtask

  task automatic model_check();
    int   o;
    logic act;
    logic [N-1:0] oh;
    o   = (m_owner < 0) ? 0 : m_owner;
    act = (m_phase == 2);
    oh  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check("gnt",         64'(gnt),         64'(oh));
    check("busy",        64'(busy),        64'(m_phase != 0));
    check("s_clr",       64'(s_clr),       64'(m_phase == 1));
    check("s_data_in",   s_data_in,        act ? u_data_in[o*DB +: DB] : 64'd0);
    check("s_last_len",  64'(s_last_len),  act ? 64'(u_last_len[o*LW +: LW]) : 64'd0);
    check("s_in_valid",  64'(s_in_valid),  64'(act & u_in_valid[o]));
    check("s_in_last",   64'(s_in_last),   64'(act & u_in_last[o]));
    check("s_out_ready", 64'(s_out_ready), 64'(act & u_out_ready[o]));
    check("u_in_ready",  64'(u_in_ready),  act ? 64'(oh & {N{s_in_ready}}) : 64'd0);
    check("u_out_valid", 64'(u_out_valid), act ? 64'(oh & {N{s_out_valid}}) : 64'd0);
    check("u_data_out",  u_data_out,       act ? s_data_out : 64'd0);
  endtask

  initial begin
    //           rst   req      rel      ordy     gnt     busy  clr   sordy
    tbl[0]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b1010, 4'b0100, 4'b1000, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b1010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, SECOND,  1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b1010, 4'b0000, SECOND,  1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req = '0; rel = '0;
    u_in_valid = '0; u_in_last = '0; u_out_ready = '0;
    u_data_in = '0; u_last_len = '0;
    s_data_out = 64'h1234567890abcdef; s_out_valid = 1'b1; s_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_gnt",  64'(gnt),  64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_clr",  64'(s_clr), 64'd0);
    check("reset_u_data_out", u_data_out, 64'd0);

    // Scripted grant/release/clear/reset sequence; outputs checked before each edge.
    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; rel = tbl[i].rel; u_out_ready = tbl[i].ordy;
      #1;
      check($sformatf("tbl%0d_gnt", i),   64'(gnt),         64'(tbl[i].gnt));
      check($sformatf("tbl%0d_busy", i),  64'(busy),        64'(tbl[i].busy));
      check($sformatf("tbl%0d_clr", i),   64'(s_clr),       64'(tbl[i].clr));
      check($sformatf("tbl%0d_sordy", i), 64'(s_out_ready), 64'(tbl[i].sordy));
    end

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_reset();

    // Random traffic against the owner/phase model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 79) == 0);
      req         = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      rel         = 4'($urandom & $urandom);
      u_in_valid  = 4'($urandom);
      u_in_last   = 4'($urandom);
      u_out_ready = 4'($urandom);
      for (int r = 0; r < N; r++) begin
        u_data_in[r*DB +: DB]  = {$urandom, $urandom};
        u_last_len[r*LW +: LW] = 7'($urandom_range(0, 64));
      end
      s_data_out  = {$urandom, $urandom};
      s_out_valid = 1'($urandom);
      s_in_ready  = 1'($urandom);
      #1;
      model_check();
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shake_arbiter.md
SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SHAKE sponge.
REQ-002 Parameter DATA_BITS, default 64, sponge data width; LEN_W = $clog2(DATA_BITS)+1 (7 at default).
REQ-003 clk  in  1  sole clock; one clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  NUM_REQ  per-requester access request (level).
REQ-006 rel  in  NUM_REQ  per-requester release pulse, one cycle.
REQ-007 gnt  out  NUM_REQ  one-hot grant, registered.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 u_data_in  in  NUM_REQ*DATA_BITS  packed requester absorb data; slice i = [i*DATA_BITS +: DATA_BITS].
REQ-010 u_in_valid, u_in_last, u_out_ready  in  NUM_REQ each  requester stream controls.
REQ-011 u_last_len  in  NUM_REQ*LEN_W  packed valid-bit count of the last block.
REQ-012 u_data_out  out  DATA_BITS  sponge squeeze data, broadcast to all requesters.
REQ-013 u_in_ready, u_out_valid  out  NUM_REQ each  per-requester handshake returns.
REQ-014 s_data_in  out  DATA_BITS; s_in_valid, s_in_last, s_out_ready  out  1 each; s_last_len  out  LEN_W: to sponge.
REQ-015 s_data_out  in  DATA_BITS; s_out_valid, s_in_ready  in  1 each: from sponge.
REQ-016 s_clr  out  1  one-cycle sponge state clear, ORed with rst at the sponge.

Function
REQ-017 FSM states: IDLE, CLEAR, ACTIVE.
REQ-018 IDLE: if any req bit high, select winner, load gnt, go CLEAR; else stay.
REQ-019 CLEAR: s_clr=1 for exactly one cycle; all u_in_ready and u_out_valid = 0; all s_* valid/ready = 0; go ACTIVE.
REQ-020 ACTIVE: granted slice g muxed combinationally: s_data_in/s_in_valid/s_in_last/s_last_len/s_out_ready from slice g; u_in_ready[g]=s_in_ready; u_out_valid[g]=s_out_valid.
REQ-021 Non-granted requesters: u_in_ready=0, u_out_valid=0 in every state.
REQ-022 Outside ACTIVE: s_in_valid=0, s_out_ready=0, s_in_last=0.
REQ-023 ACTIVE with rel[g]=1: mux still active that cycle; next cycle gnt=0, state IDLE.
REQ-024 rel from non-granted requester, or any rel in IDLE/CLEAR: ignored.
REQ-025 req sampled only in IDLE; dropping req while granted does not end the grant.
REQ-026 Latency: req high at IDLE edge t -> gnt and s_clr high at t+1, first transfer possible at t+2.
REQ-027 Handoff: rel at cycle t -> IDLE at t+1 -> new gnt at t+2; minimum 2 cycles with no transfer between owners.
REQ-028 Round-robin: pointer holds last granted index; search starts at pointer+1 mod NUM_REQ; pointer updates on each grant.
REQ-029 Simultaneous rel[g] and req[g] still high: g re-arbitrated normally, wins only if no other requester precedes it in search order.

Reset
REQ-030 On rst: state IDLE, gnt=0, busy=0, s_clr=0, pointer=NUM_REQ-1 (requester 0 searched first); all stream outputs 0.
REQ-031 rst mid-transaction aborts grant immediately; requesters must restart their message.

Configuration
REQ-032 Macro SHAKE_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins, pointer unused; undefined -> round-robin per REQ-028.

Verification
REQ-033 req=4'b0001, absorb one 64-bit block 64'h1234567890abcdef with last_len=64, squeeze 4 words, rel -> gnt=0001 at t+1, s_clr one cycle, output matches SHAKE256 model, IDLE after rel.
REQ-034 req=4'b1010 at once, both release after 2 words -> grant order 0010 then 1000; next req=1010 again -> 0010 (round-robin); with SHAKE_ARB_FIXED_PRIO_EN order 0010, 0010.
REQ-035 req 0 granted, requester 2 drives u_in_valid=1 and rel[2]=1 -> s_in_valid follows requester 0 only, u_in_ready[2]=0, grant unchanged.
REQ-036 Back-to-back: two requesters hash identical seed sequentially -> identical squeeze words (s_clr verified), exactly 2 dead cycles between owners.
REQ-037 rst asserted during requester 1 squeeze -> next cycle gnt=0, busy=0, s_out_ready=0; after rst, req=0010 -> gnt=0001? no: gnt=0010 at t+1.
REQ-038 rel asserted in CLEAR cycle -> ignored; state reaches ACTIVE, grant held until later rel.
